uart_mmio_tx: RTL
=================

UART_MMIO_TX -- requirements
Module: uart_mmio_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning transmit FIFO entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mmio_wea  input  1  one-cycle write strobe from the Memory stage.
REQ-006 SHALL have port mmio_dat  input  32  write data; only bits [7:0] are transmitted.
REQ-007 SHALL have port tx  output  1  UART serial line, 8N1, idle high.
REQ-008 SHALL have port tx_busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-009 SHALL have port fifo_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.
REQ-011 SHALL have port overflow  output  1  sticky: a write was dropped.

Function
REQ-012 SHALL push mmio_dat[7:0] into the FIFO on each clk edge where mmio_wea=1 and the FIFO is not full.
REQ-013 SHALL drop a write when mmio_wea=1 and the FIFO is full at that edge, set overflow=1, and leave FIFO contents unchanged.
REQ-014 SHALL accept a push on the same edge as a pop when the FIFO is full, keeping fifo_count unchanged and overflow unchanged.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 SHALL, in IDLE with fifo_count>0, pop the head byte into an 8-bit shift register and enter START on the next edge.
REQ-017 SHALL drive tx=0 for exactly CLKS_PER_BIT cycles in START, then enter DATA.
REQ-018 SHALL drive the 8 data bits LSB first in DATA, each for exactly CLKS_PER_BIT cycles, using a 3-bit bit index, then enter STOP.
REQ-019 SHALL drive tx=1 for exactly CLKS_PER_BIT cycles in STOP, then return to IDLE.
REQ-020 SHALL drive tx=1 in IDLE.
REQ-021 SHALL register tx so that it changes only on clk edges.
REQ-022 SHALL therefore space back-to-back frames 10*CLKS_PER_BIT+1 cycles apart, start edge to start edge.
REQ-023 SHALL use a baud counter counting 0..CLKS_PER_BIT-1, cleared on every state entry.
REQ-024 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.
REQ-025 SHALL derive fifo_count from pointers carrying one extra wrap bit.
REQ-026 SHALL set tx_busy = (state != IDLE) || (fifo_count != 0).
REQ-027 SHALL never pop from an empty FIFO; the FSM stays in IDLE.

Reset
REQ-028 SHALL, when Rst=1 at a clk edge, set state=IDLE, tx=1, FIFO pointers=0, fifo_count=0, fifo_full=0, overflow=0, tx_busy=0, and clear the baud counter and bit index.
REQ-029 SHALL, on reset mid-frame, abort the frame immediately (tx=1 the next cycle), discard all queued bytes, and emit no partial frame afterward.
REQ-030 SHALL ignore mmio_wea on any edge where Rst=1.
REQ-031 SHALL clear overflow only by reset.

Structure
REQ-032 SHALL place the tx state enum (IDLE, START, DATA, STOP) and the default CLKS_PER_BIT constant in shared package uart_pkg, for reuse by the UART receive side.
REQ-033 SHALL implement the FIFO as one sub-module tx_fifo with push, pop, din, dout, full, empty, count; the FSM and baud logic stay in uart_mmio_tx.
REQ-034 SHALL contain no combinational path from mmio_wea to tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-035 SHALL verify single byte: write 0x000000A5 -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; tx_busy falls after STOP.
REQ-036 SHALL verify back-to-back: write 0x11, 0x22, 0x33 on consecutive cycles -> three frames, start edges 41 cycles apart, bytes in order.
REQ-037 SHALL verify overflow: 6 consecutive writes while idle -> first byte in flight, 4 queued (fifo_full=1), sixth dropped, overflow=1, exactly 5 frames sent.
REQ-038 SHALL verify simultaneous push/pop: FIFO full in IDLE, write 0x5A on the pop edge -> fifo_count stays 4, overflow stays 0, 0x5A transmitted last.
REQ-039 SHALL verify reset mid-frame: assert Rst during DATA bit 3 of 0xFF -> tx=1 the next cycle, fifo_count=0, no further frames.
REQ-040 SHALL verify upper bits ignored: write 0xDEADBE00 -> transmitted byte is 0x00.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: transmit-side state encoding and default bit timing, shared with the UART receiver
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO with wrap-bit pointers; a push while full is taken only alongside a pop
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    Rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [7:0]              din,
    output logic [7:0]              dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic        do_push, do_pop;

    assign count   = wr_q - rd_q;
    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= din;
                wr_q <= wr_q + (AW+1)'(1);
            end
            if (do_pop) rd_q <= rd_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_mmio_tx.sv
// uart_mmio_tx: MMIO-fed 8N1 UART transmitter; bytes queue in tx_fifo and leave LSB first
module uart_mmio_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         Rst,
    input  logic                         mmio_wea,
    input  logic [31:0]                  mmio_dat,
    output logic                         tx,
    output logic                         tx_busy,
    output logic                         fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;
    logic          pop, empty, baud_done;
    logic [7:0]    head;
    logic          dat_unused;

    assign dat_unused = ^mmio_dat[31:8];

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .Rst   (Rst),
        .push  (mmio_wea),
        .pop   (pop),
        .din   (mmio_dat[7:0]),
        .dout  (head),
        .full  (fifo_full),
        .empty (empty),
        .count (fifo_count)
    );

    assign baud_done = baud_q == BAUD_LAST;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                pop     = !empty;
                state_d = empty ? IDLE : START;
                shift_d = empty ? shift_q : head;
                bit_d   = '0;
            end
            START: state_d = baud_done ? DATA : START;
            DATA: begin
                state_d = (baud_done && bit_q == 3'd7) ? STOP : DATA;
                bit_d   = baud_done ? bit_q + 3'd1 : bit_q;
                shift_d = baud_done ? shift_q >> 1 : shift_q;
            end
            STOP:    state_d = baud_done ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
        // every state change happens on baud_done or out of IDLE, so this also clears on entry
        baud_d = (state_q == IDLE || baud_done) ? '0 : baud_q + CW'(1);
        tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
        ovf_d  = ovf_q || (mmio_wea && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx       = tx_q;
    assign tx_busy  = (state_q != IDLE) || !empty;
    assign overflow = ovf_q;

endmodule
